// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 receiver with glitch filter, prefix merge and FWFT event FIFO
module ps2_rx_fifo #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          ps2_bus,
    input  logic                rd,
    output logic                ev_valid,
    output logic [9:0]          ev_data,
    output logic [DEPTH_LOG2:0] ev_count,
    output logic                overflow,
    output logic                frame_err,
    input  logic                clr_err
);
    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [8:0]  FILT_LIM = 9'(FILTER_LEN);
    localparam logic [19:0] TMO_LIM  = 20'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // Lane 1 is the PS/2 clock, lane 0 is the PS/2 data line.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      filt_q, filt_d;
    logic [1:0][7:0] fcnt_q, fcnt_d;
    logic            clk_prev_q, clk_prev_d;

    state_t          state_q, state_d;
    logic [10:0]     frame_q, frame_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [19:0]     tcnt_q, tcnt_d;
    logic            ext_pend_q, ext_pend_d;
    logic            up_pend_q, up_pend_d;

    logic [9:0]            mem_q [DEPTH];
    logic [9:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  ferr_q, ferr_d;

    logic        fall;
    logic        dat;
    logic [19:0] tcnt_inc;
    logic        timeout;
    logic [7:0]  code;
    logic        frame_ok;
    logic        push;
    logic        err_set;
    logic        ext_set;
    logic        up_set;
    logic        pend_clr;
    logic        not_empty;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic        ovf_set;

    // Two-flop synchronisers, then per-lane persistence filters on the synchronised lines.
    always_comb begin
        sync1_d    = ps2_bus;
        sync2_d    = sync1_q;
        clk_prev_d = filt_q[1];
        filt_d     = filt_q;
        fcnt_d     = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                fcnt_d[i] = 8'd0;
            end else if (({1'b0, fcnt_q[i]} + 9'd1) == FILT_LIM) begin
                filt_d[i] = ~filt_q[i];
                fcnt_d[i] = 8'd0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + 8'd1;
            end
        end
    end

    assign fall     = clk_prev_q & ~filt_q[1];
    assign dat      = filt_q[0];
    assign tcnt_inc = tcnt_q + 20'd1;
    // A falling edge in the same cycle restarts the count, so it always beats the timeout.
    assign timeout  = (state_q == S_RECV) && !fall && (tcnt_inc == TMO_LIM);
    assign code     = frame_q[8:1];
    // Frame is LSB-first: [0]=start, [8:1]=code, [9]=parity, [10]=stop; parity is odd.
    assign frame_ok = ~frame_q[0] & frame_q[10] & (^frame_q[9:1]);

    // Receiver next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fall && !dat) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (fall) begin
                    if (bitcnt_q == 4'd10) begin
                        state_d = S_CHECK;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Receiver outputs: event push, prefix tracking and error reporting.
    always_comb begin
        push     = 1'b0;
        err_set  = 1'b0;
        ext_set  = 1'b0;
        up_set   = 1'b0;
        pend_clr = 1'b0;
        case (state_q)
            S_RECV: begin
                if (timeout) begin
                    err_set  = 1'b1;
                    pend_clr = 1'b1;
                end
            end
            S_CHECK: begin
                if (!frame_ok) begin
                    err_set  = 1'b1;
                    pend_clr = 1'b1;
                end else if (code == 8'hE0) begin
                    ext_set = 1'b1;
                end else if (code == 8'hF0) begin
                    up_set = 1'b1;
                end else begin
                    push     = 1'b1;
                    pend_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Receiver datapath: shift register, bit counter, stall timer and prefix flags.
    always_comb begin
        frame_d    = frame_q;
        bitcnt_d   = bitcnt_q;
        tcnt_d     = 20'd0;
        ext_pend_d = ext_pend_q;
        up_pend_d  = up_pend_q;
        case (state_q)
            S_IDLE: begin
                if (fall && !dat) begin
                    frame_d  = {1'b0, frame_q[10:1]};
                    bitcnt_d = 4'd1;
                end
            end
            S_RECV: begin
                if (fall) begin
                    frame_d  = {dat, frame_q[10:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                end else if (timeout) begin
                    bitcnt_d = 4'd0;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            S_CHECK: bitcnt_d = 4'd0;
            default: bitcnt_d = 4'd0;
        endcase
        if (pend_clr) begin
            ext_pend_d = 1'b0;
            up_pend_d  = 1'b0;
        end else begin
            if (ext_set) begin
                ext_pend_d = 1'b1;
            end
            if (up_set) begin
                up_pend_d = 1'b1;
            end
        end
    end

    assign not_empty = (count_q != '0);
    assign full      = count_q[DEPTH_LOG2];
    assign pop       = rd & not_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
    assign push_ok   = push & (~full | pop);
    assign ovf_set   = push & full & ~pop;

    // FIFO storage, pointers, occupancy and sticky flags.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = {up_pend_q, ext_pend_q, code};
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d  = ovf_set ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
        ferr_d = err_set ? 1'b1 : (clr_err ? 1'b0 : ferr_q);
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Conditioning, receiver datapath and FIFO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q     <= '0;
            clk_prev_q <= 1'b1;
            frame_q    <= '0;
            bitcnt_q   <= '0;
            tcnt_q     <= '0;
            ext_pend_q <= 1'b0;
            up_pend_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            clk_prev_q <= clk_prev_d;
            frame_q    <= frame_d;
            bitcnt_q   <= bitcnt_d;
            tcnt_q     <= tcnt_d;
            ext_pend_q <= ext_pend_d;
            up_pend_q  <= up_pend_d;
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
        end
    end

    assign ev_valid  = not_empty;
    assign ev_data   = not_empty ? mem_q[rptr_q] : 10'd0;
    assign ev_count  = count_q;
    assign overflow  = ovf_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int DEPTH_LOG2 = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                ps2_clk;
    logic                ps2_data;
    logic [1:0]          ps2_bus;
    logic                rd;
    logic                clr_err;
    logic                ev_valid;
    logic [9:0]          ev_data;
    logic [DEPTH_LOG2:0] ev_count;
    logic                overflow;
    logic                frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    assign ps2_bus = {ps2_clk, ps2_data};

    ps2_rx_fifo #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_bus  (ps2_bus),
        .rd       (rd),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_count (ev_count),
        .overflow (overflow),
        .frame_err(frame_err),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 40-clk bit period: data set, 10 high, 20 low, 10 high.  With pop_at_check
    // rd is pulsed in the cycle the stop-bit CHECK pushes (fall filtered 10 posedges
    // after the drop, CHECK on the 11th, write at the 12th).
    task automatic send_frame(input logic [7:0] code, input logic bad_par,
                              input int nbits, input logic pop_at_check);
        logic [10:0] bits;
        bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(10);
            ps2_clk = 1'b0;
            if (pop_at_check && i == 10) begin
                tick(11);
                rd = 1'b1;
                tick(1);
                rd = 1'b0;
                tick(8);
            end else begin
                tick(20);
            end
            ps2_clk = 1'b1;
            tick(10);
        end
        ps2_data = 1'b1;
        tick(30);
    endtask

    task automatic pop_one();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_checks++;
        if ({ev_valid, ev_data, ev_count, overflow, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d o=%b e=%b required all 0",
                     ev_valid, ev_data, ev_count, overflow, frame_err);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single_make();
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        n_checks++;
        if (ev_valid !== 1'b1 || ev_data !== 10'h01C || ev_count !== 4'd1) begin
            n_fail++;
            $display("FAIL single_make: got v=%b d=%h c=%0d required v=1 d=01c c=1",
                     ev_valid, ev_data, ev_count);
        end
        pop_one();
        n_checks++;
        if (ev_valid !== 1'b0 || ev_count !== 4'd0 || ev_data !== 10'h000) begin
            n_fail++;
            $display("FAIL single_pop: got v=%b d=%h c=%0d required v=0 d=000 c=0",
                     ev_valid, ev_data, ev_count);
        end
    endtask

    task automatic test_ext_break();
        send_frame(8'hE0, 1'b0, 11, 1'b0);
        send_frame(8'hF0, 1'b0, 11, 1'b0);
        n_checks++;
        if (ev_count !== 4'd0) begin
            n_fail++;
            $display("FAIL prefix_no_push: got c=%0d required 0", ev_count);
        end
        send_frame(8'h75, 1'b0, 11, 1'b0);
        n_checks++;
        if (ev_count !== 4'd1 || ev_data !== 10'h375) begin
            n_fail++;
            $display("FAIL ext_break: got d=%h c=%0d required d=375 c=1", ev_data, ev_count);
        end
        pop_one();
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        n_checks++;
        if (ev_count !== 4'd1 || ev_data !== 10'h01C) begin
            n_fail++;
            $display("FAIL prefix_cleared: got d=%h c=%0d required d=01c c=1", ev_data, ev_count);
        end
        pop_one();
    endtask

    task automatic test_parity_error();
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        n_checks++;
        if (frame_err !== 1'b1 || ev_count !== 4'd0) begin
            n_fail++;
            $display("FAIL parity_err: got e=%b c=%0d required e=1 c=0", frame_err, ev_count);
        end
        send_frame(8'h2D, 1'b0, 11, 1'b0);
        n_checks++;
        if (ev_valid !== 1'b1 || ev_data !== 10'h02D) begin
            n_fail++;
            $display("FAIL after_parity: got v=%b d=%h required v=1 d=02d", ev_valid, ev_data);
        end
        pop_one();
        pulse_clr();
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_err: got e=%b required 0", frame_err);
        end
    endtask

    task automatic test_glitch_timeout();
        ps2_data = 1'b0;
        tick(20);
        ps2_clk = 1'b0;
        tick(FILTER_LEN - 1);
        ps2_clk = 1'b1;
        tick(20);
        ps2_data = 1'b1;
        tick(20);
        n_checks++;
        if (ev_count !== 4'd0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: got c=%0d e=%b required c=0 e=0", ev_count, frame_err);
        end
        send_frame(8'h15, 1'b0, 11, 1'b0);
        n_checks++;
        if (ev_count !== 4'd1 || ev_data !== 10'h015) begin
            n_fail++;
            $display("FAIL after_glitch: got d=%h c=%0d required d=015 c=1", ev_data, ev_count);
        end
        pop_one();
        send_frame(8'h15, 1'b0, 10, 1'b0);
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL early_timeout: got e=%b required 0", frame_err);
        end
        tick(TIMEOUT + 50);
        n_checks++;
        if (frame_err !== 1'b1 || ev_count !== 4'd0) begin
            n_fail++;
            $display("FAIL timeout: got e=%b c=%0d required e=1 c=0", frame_err, ev_count);
        end
        pulse_clr();
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clr: got e=%b required 0", frame_err);
        end
        send_frame(8'h15, 1'b0, 11, 1'b0);
        n_checks++;
        if (ev_count !== 4'd1 || ev_data !== 10'h015 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_timeout: got d=%h c=%0d e=%b required d=015 c=1 e=0",
                     ev_data, ev_count, frame_err);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [9:0] exp;
        for (int c = 1; c <= 9; c++) begin
            send_frame(8'(c), 1'b0, 11, 1'b0);
        end
        n_checks++;
        if (ev_count !== 4'd8 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got c=%0d o=%b required c=8 o=1", ev_count, overflow);
        end
        for (int i = 1; i <= 8; i++) begin
            exp = 10'(i);
            n_checks++;
            if (ev_valid !== 1'b1 || ev_data !== exp) begin
                n_fail++;
                $display("FAIL ovf_order[%0d]: got v=%b d=%h required v=1 d=%h",
                         i, ev_valid, ev_data, exp);
            end
            pop_one();
        end
        n_checks++;
        if (ev_valid !== 1'b0 || ev_count !== 4'd0) begin
            n_fail++;
            $display("FAIL ovf_drained: got v=%b c=%0d required v=0 c=0", ev_valid, ev_count);
        end
        pulse_clr();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: got o=%b required 0", overflow);
        end
    endtask

    task automatic test_full_pop_push();
        logic [9:0] exp;
        for (int c = 1; c <= 8; c++) begin
            send_frame(8'(c), 1'b0, 11, 1'b0);
        end
        n_checks++;
        if (ev_count !== 4'd8 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill: got c=%0d o=%b required c=8 o=0", ev_count, overflow);
        end
        send_frame(8'h0A, 1'b0, 11, 1'b1);
        n_checks++;
        if (ev_count !== 4'd8 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_push: got c=%0d o=%b required c=8 o=0", ev_count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            exp = (i == 7) ? 10'h00A : 10'(i + 2);
            n_checks++;
            if (ev_data !== exp) begin
                n_fail++;
                $display("FAIL fpp_order[%0d]: got d=%h required d=%h", i, ev_data, exp);
            end
            pop_one();
        end
        n_checks++;
        if (ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fpp_drained: got v=%b required 0", ev_valid);
        end
        rd = 1'b1;
        tick(3);
        rd = 1'b0;
        n_checks++;
        if (ev_valid !== 1'b0 || ev_count !== 4'd0 || ev_data !== 10'h000) begin
            n_fail++;
            $display("FAIL underflow: got v=%b d=%h c=%0d required v=0 d=000 c=0",
                     ev_valid, ev_data, ev_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h33, 1'b0, 11, 1'b0);
        send_frame(8'h44, 1'b1, 11, 1'b0);
        n_checks++;
        if (ev_count !== 4'd1 || frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got c=%0d e=%b required c=1 e=1", ev_count, frame_err);
        end
        send_frame(8'h1C, 1'b0, 5, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_checks++;
        if ({ev_valid, ev_data, ev_count, overflow, frame_err} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b d=%h c=%0d o=%b e=%b required all 0",
                     ev_valid, ev_data, ev_count, overflow, frame_err);
        end
        tick(5);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        n_checks++;
        if (ev_count !== 4'd1 || ev_data !== 10'h01C || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got d=%h c=%0d e=%b required d=01c c=1 e=0",
                     ev_data, ev_count, frame_err);
        end
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd       = 1'b0;
        clr_err  = 1'b0;
        test_reset();
        test_single_make();
        test_ext_break();
        test_parity_error();
        test_glitch_timeout();
        test_overflow();
        test_full_pop_push();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
